// File: rtl/telemetry_uart_framer.sv
// Telemetry framer: accumulates vin/vout over 2^LOG2_WIN samples and sends a
// 6-byte summary frame (A5, avg vin, avg vout, min, max, xor) on a UART 8N1 line.
module telemetry_uart_framer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int LOG2_WIN     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_valid,
  input  logic [7:0] vin,
  input  logic [7:0] vout,
  output logic       tx,
  output logic       busy,
  output logic       overrun
);

  localparam int SUM_W = 8 + LOG2_WIN;
  localparam int CNT_W = LOG2_WIN + 1;
  localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_WIN) - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0]       SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  logic [SUM_W-1:0] sum_vin_q, sum_vin_d, sum_vout_q, sum_vout_d;
  logic [SUM_W-1:0] sum_vin_acc, sum_vout_acc;
  logic [7:0]       min_q, min_d, max_q, max_d, min_acc, max_acc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             win_done, accept;
  logic             start_q, overrun_q;

  logic [7:0]       avg_vin_q, avg_vout_q, fmin_q, fmax_q, cur_byte;
  tx_state_e        state_q, state_d;
  logic [2:0]       byte_idx_q, byte_idx_d, bit_idx_q, bit_idx_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             tx_q, tx_d, busy_q, busy_d;

  function automatic logic [7:0] avg_trunc(input logic [SUM_W-1:0] sum);
    return sum[LOG2_WIN +: 8];
  endfunction

  always_comb begin
    sum_vin_acc  = sum_vin_q + SUM_W'(vin);
    sum_vout_acc = sum_vout_q + SUM_W'(vout);
    min_acc      = (vout < min_q) ? vout : min_q;
    max_acc      = (vout > max_q) ? vout : max_q;
    win_done     = sample_valid && (cnt_q == CNT_LAST);
    sum_vin_d    = sum_vin_q;
    sum_vout_d   = sum_vout_q;
    min_d        = min_q;
    max_d        = max_q;
    cnt_d        = cnt_q;
    if (sample_valid) begin
      if (win_done) begin
        sum_vin_d  = '0;
        sum_vout_d = '0;
        min_d      = 8'hFF;
        max_d      = 8'h00;
        cnt_d      = '0;
      end else begin
        sum_vin_d  = sum_vin_acc;
        sum_vout_d = sum_vout_acc;
        min_d      = min_acc;
        max_d      = max_acc;
        cnt_d      = cnt_q + CNT_W'(1);
      end
    end
  end

  // A pending start counts as busy so a frame is never overwritten before it goes out.
  assign accept = win_done && (state_q == IDLE) && !start_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      avg_vin_q  <= avg_trunc(sum_vin_acc);
      avg_vout_q <= avg_trunc(sum_vout_acc);
      fmin_q     <= min_acc;
      fmax_q     <= max_acc;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    timer_d    = timer_q;
    case (state_q)
      IDLE: begin
        if (start_q) begin
          state_d    = START;
          byte_idx_d = 3'd0;
          timer_d    = '0;
        end
      end
      START: begin
        timer_d = timer_q + TMR_W'(1);
        if (timer_q == TMR_LAST) begin
          timer_d   = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        timer_d = timer_q + TMR_W'(1);
        if (timer_q == TMR_LAST) begin
          timer_d = '0;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      default: begin
        timer_d = timer_q + TMR_W'(1);
        if (timer_q == TMR_LAST) begin
          timer_d = '0;
          if (byte_idx_q == 3'd5) begin
            state_d = IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
            state_d    = START;
          end
        end
      end
    endcase

    case (byte_idx_d)
      3'd0:    cur_byte = SYNC_BYTE;
      3'd1:    cur_byte = avg_vin_q;
      3'd2:    cur_byte = avg_vout_q;
      3'd3:    cur_byte = fmin_q;
      3'd4:    cur_byte = fmax_q;
      default: cur_byte = avg_vin_q ^ avg_vout_q ^ fmin_q ^ fmax_q;
    endcase

    // Line level follows the next state so tx and busy leave registers directly.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_vin_q  <= '0;
      sum_vout_q <= '0;
      min_q      <= 8'hFF;
      max_q      <= 8'h00;
      cnt_q      <= '0;
      start_q    <= 1'b0;
      overrun_q  <= 1'b0;
      state_q    <= IDLE;
      byte_idx_q <= 3'd0;
      bit_idx_q  <= 3'd0;
      timer_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      sum_vin_q  <= sum_vin_d;
      sum_vout_q <= sum_vout_d;
      min_q      <= min_d;
      max_q      <= max_d;
      cnt_q      <= cnt_d;
      if (accept) start_q <= 1'b1;
      else if (start_q && state_q == IDLE) start_q <= 1'b0;
      if (win_done && !accept) overrun_q <= 1'b1;
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      timer_q    <= timer_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_telemetry_uart_framer.sv
// Scoreboard bench for telemetry_uart_framer: a window-level reference model predicts
// frames and overrun; monitors decode the UART line and compare against the queue.
module tb_telemetry_uart_framer;

  localparam int CPB       = 4;
  localparam int LG        = 2;
  localparam int WIN       = 1 << LG;
  localparam int LGB       = 8;
  localparam int WINB      = 1 << LGB;
  localparam int FRAME_CYC = 60 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_valid = 1'b0;
  logic       sample_valid_b = 1'b0;
  logic [7:0] vin = 8'd0;
  logic [7:0] vout = 8'd0;
  logic       tx, busy, overrun;
  logic       tx_b, busy_b, overrun_b;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  telemetry_uart_framer #(.CLKS_PER_BIT(CPB), .LOG2_WIN(LG)) u_dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .vin(vin), .vout(vout),
    .tx(tx), .busy(busy), .overrun(overrun));

  telemetry_uart_framer #(.CLKS_PER_BIT(CPB), .LOG2_WIN(LGB)) u_big (
    .clk(clk), .reset(reset), .sample_valid(sample_valid_b), .vin(vin), .vout(vout),
    .tx(tx_b), .busy(busy_b), .overrun(overrun_b));

  typedef struct {
    logic [47:0] frame;
    int          start;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_b[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_active [2];

  int   mvi[$], mvo[$], bvi[$], bvo[$];
  int   busy_start = 0;
  int   busy_until = -1;
  bit   m_overrun = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Frame contents straight from the window definition: truncated means, min, max, xor.
  function automatic logic [47:0] ref_frame(input int vi[$], input int vo[$], input int lg);
    int svi = 0;
    int svo = 0;
    int mn = 255;
    int mx = 0;
    logic [7:0] a, b, c, d;
    foreach (vi[i]) begin
      svi += vi[i];
      svo += vo[i];
      if (vo[i] < mn) mn = vo[i];
      if (vo[i] > mx) mx = vo[i];
    end
    a = 8'(svi / (1 << lg));
    b = 8'(svo / (1 << lg));
    c = 8'(mn);
    d = 8'(mx);
    return {8'hA5, a, b, c, d, a ^ b ^ c ^ d};
  endfunction

  function automatic logic txv(input int w);
    return (w != 0) ? tx_b : tx;
  endfunction

  function automatic logic bsv(input int w);
    return (w != 0) ? busy_b : busy;
  endfunction

  task automatic step(input bit sv, input bit svb, input int vi, input int vo);
    logic [47:0] f;
    exp_t e;
    sample_valid   = sv;
    sample_valid_b = svb;
    vin  = 8'(vi);
    vout = 8'(vo);
    @(posedge clk);
    #1;
    if (sv) begin
      mvi.push_back(vi & 255);
      mvo.push_back(vo & 255);
      if (mvi.size() == WIN) begin
        f = ref_frame(mvi, mvo, LG);
        if (cyc > busy_until) begin
          e.frame = f;
          e.start = cyc + 1;
          exp_q.push_back(e);
          busy_start = cyc + 1;
          busy_until = cyc + 1 + FRAME_CYC;
        end else begin
          m_overrun = 1'b1;
        end
        mvi.delete();
        mvo.delete();
      end
    end
    if (svb) begin
      bvi.push_back(vi & 255);
      bvo.push_back(vo & 255);
      if (bvi.size() == WINB) begin
        e.frame = ref_frame(bvi, bvo, LGB);
        e.start = cyc + 1;
        exp_b.push_back(e);
        bvi.delete();
        bvo.delete();
      end
    end
    check("busy", 64'(busy), 64'(cyc >= busy_start && cyc < busy_until));
    check("overrun", 64'(overrun), 64'(m_overrun));
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    sample_valid = 1'b0;
    sample_valid_b = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("reset_tx", 64'(tx), 64'd1);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_overrun", 64'(overrun), 64'd0);
      check("reset_big_busy", 64'(busy_b), 64'd0);
      @(negedge clk);
    end
    reset = 1'b0;
    mvi.delete(); mvo.delete(); bvi.delete(); bvo.delete();
    exp_q.delete(); exp_b.delete();
    busy_start = 0;
    busy_until = -1;
    m_overrun = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || exp_b.size() != 0 || mon_active[0] || mon_active[1] ||
            busy || busy_b) && n < 3000) begin
      step(1'b0, 1'b0, 0, 0);
      n++;
    end
    check("idle_timeout", 64'(n < 3000), 64'd1);
  endtask

  task automatic run_monitor(input int which);
    logic        smp [FRAME_CYC];
    logic [47:0] f;
    exp_t        e;
    bit          have, aborted, busy_ok, fmt_ok;
    int          st;
    string       pfx;
    pfx = (which != 0) ? "big_" : "";
    forever begin
      @(negedge clk);
      if (!reset && txv(which) === 1'b0) begin
        mon_active[which] = 1'b1;
        st = cyc;
        have = 1'b0;
        if (which == 0 && exp_q.size() > 0) begin e = exp_q.pop_front(); have = 1'b1; end
        if (which != 0 && exp_b.size() > 0) begin e = exp_b.pop_front(); have = 1'b1; end
        aborted = 1'b0;
        busy_ok = 1'b1;
        for (int k = 0; k < FRAME_CYC; k++) begin
          if (k > 0) @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          smp[k] = txv(which);
          if (bsv(which) !== 1'b1) busy_ok = 1'b0;
        end
        if (!aborted) begin
          @(negedge clk);
          if (!reset) begin
            check({pfx, "frame_expected"}, 64'(have), 64'd1);
            check({pfx, "busy_during_frame"}, 64'(busy_ok), 64'd1);
            check({pfx, "busy_after_frame"}, 64'(bsv(which)), 64'd0);
            check({pfx, "tx_after_frame"}, 64'(txv(which)), 64'd1);
            fmt_ok = 1'b1;
            f = '0;
            for (int i = 0; i < 6; i++) begin
              for (int j = 0; j < 10; j++) begin
                if (j == 0) begin
                  if (smp[(i * 10 + j) * CPB + CPB / 2] !== 1'b0) fmt_ok = 1'b0;
                end else if (j == 9) begin
                  if (smp[(i * 10 + j) * CPB + CPB / 2] !== 1'b1) fmt_ok = 1'b0;
                end else begin
                  f[(5 - i) * 8 + (j - 1)] = smp[(i * 10 + j) * CPB + CPB / 2];
                end
              end
            end
            check({pfx, "framing"}, 64'(fmt_ok), 64'd1);
            if (have) begin
              check({pfx, "frame_bytes"}, 64'(f), 64'(e.frame));
              check({pfx, "frame_start_cycle"}, 64'(st), 64'(e.start));
            end
          end
        end
        mon_active[which] = 1'b0;
      end
    end
  endtask

  initial run_monitor(0);
  initial run_monitor(1);

  initial begin
    int c;
    int dens;
    do_reset(3);
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b0, 0, 0);
      check("idle_tx", 64'(tx), 64'd1);
    end

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 10, 20);
    wait_idle();

    for (int i = 0; i < 4; i++) begin
      case (i)
        0: step(1'b1, 1'b0, 20, 20);
        1: step(1'b1, 1'b0, 20, 50);
        2: step(1'b1, 1'b0, 20, 100);
        default: step(1'b1, 1'b0, 20, 10);
      endcase
      for (int g = 0; g <= i; g++) step(1'b0, 1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end
    wait_idle();

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 255, 255);
    wait_idle();

    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1, 1);
    wait_idle();
    check("overrun_sticky", 64'(overrun), 64'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1, 1);
    wait_idle();
    do_reset(2);

    // Window lands on the edge busy falls (overrun), then one edge later (accepted).
    for (int off = 3; off >= 2; off--) begin
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 30 + i, 40 + i);
      c = cyc;
      while (cyc < c + FRAME_CYC - off) step(1'b0, 1'b0, 0, 0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 7 * i, 200 - i);
      wait_idle();
      check("boundary_overrun", 64'(overrun), 64'(off == 3));
      do_reset(2);
    end

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    c = cyc;
    while (cyc < c + 1 + 100) step(1'b0, 1'b0, 0, 0);
    do_reset(2);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    wait_idle();

    for (int blk = 0; blk < 8; blk++) begin
      dens = int'($urandom_range(2, 90));
      for (int i = 0; i < 500; i++)
        step(($urandom_range(0, 99) < dens), 1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      if (blk % 3 == 2) begin
        wait_idle();
        do_reset(2);
      end
    end
    wait_idle();

    do_reset(2);
    for (int i = 0; i < WINB; i++) step(1'b0, 1'b1, 255, 255);
    wait_idle();
    for (int i = 0; i < WINB; i++) step(1'b0, 1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    wait_idle();
    check("big_overrun", 64'(overrun_b), 64'd0);
    check("leftover_expected", 64'(exp_q.size() + exp_b.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/telemetry_uart_framer.md
# telemetry_uart_framer

Downstream telemetry stage of the converter. Consumes the per-sample input voltage code and regulated output code from the converter core, accumulates them over a power-of-two window, and serializes a fixed 6-byte summary frame (average Vin, average Vout, min/max Vout, checksum) out of a single UART 8N1 pin for off-chip logging. Accumulation runs continuously and is independent of transmission; a window that completes while a frame is still being sent is dropped and flagged.

## Interface
Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- LOG2_WIN, 4: window length is 2^LOG2_WIN samples; legal range 1..8.

Ports:
- clk  input  1  single system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high; overrides all other inputs.
- sample_valid  input  1  vin/vout sampled on this edge when high.
- vin  input  8  input voltage code, unsigned.
- vout  input  8  converter output code, unsigned.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high while a frame is being shifted out.
- overrun  output  1  sticky; a completed window was dropped.

## Operation
- Accumulators: sum_vin, sum_vout, each 8+LOG2_WIN bits unsigned (no overflow possible); min_vout init 0xFF; max_vout init 0x00; sample counter LOG2_WIN+1 bits.
- Every edge with sample_valid=1: add vin/vout to sums, update min/max, increment counter. sample_valid=0: no change.
- Window complete = edge accepting sample number 2^LOG2_WIN. On that edge, compute with that sample included: avg_vin = sum_vin >> LOG2_WIN, avg_vout = sum_vout >> LOG2_WIN (truncation), min, max. Accumulators, min/max and counter restart to init values (sample on that edge belongs to the finished window only).
- If transmitter idle at window completion: latch frame bytes, start transmission. If busy: frame discarded, overrun set to 1 (stays until reset); transmission in progress unaffected.
- Frame byte order: B0=0xA5, B1=avg_vin, B2=avg_vout, B3=min_vout, B4=max_vout, B5=B1^B2^B3^B4.
- Each byte: start bit 0, 8 data bits LSB first, stop bit 1; each bit exactly CLKS_PER_BIT cycles. Bytes back-to-back, no idle gap between stop bit and next start bit.
- TX FSM states: IDLE → START → DATA (8 bits) → STOP → START of next byte, or IDLE after B5 stop bit. Byte index 0..5, bit index 0..7, bit timer 0..CLKS_PER_BIT-1.

## Timing
- Reset (any state, including mid-frame): next edge tx=1, busy=0, overrun=0, FSM IDLE, accumulators/counter/min/max at init. Partial frame abandoned; no resume.
- Window completes at edge E: tx falls and busy rises at edge E+1 (tx, busy registered).
- Frame duration: 60×CLKS_PER_BIT cycles from edge E+1; tx returns to idle 1 as stop bit of B5 ends; busy falls at the same edge the FSM returns to IDLE.
- Window completing on exactly the edge busy falls (FSM entering IDLE): treated as busy → overrun. Window completing one or more edges after busy=0: accepted.
- Accumulation never stalls; sample_valid accepted every cycle including while busy.

## Test plan
(CLKS_PER_BIT=4, LOG2_WIN=2 unless noted)
- Reset held 3 cycles, then released with sample_valid=0 for 50 cycles -> tx=1, busy=0, overrun=0 throughout.
- 4 samples vin=10, vout=20 -> busy rises one edge after 4th sample; decoded bytes A5 0A 14 14 14 1E; frame 240 cycles; overrun=0.
- vin=20 ×4, vout=20,50,100,10 with sample_valid gaps between samples -> A5 14 2D 0A 64 57; gap cycles ignored.
- vin=255, vout=255 ×4 -> A5 FF FF FF FF 00 (no sum wrap); repeat with LOG2_WIN=8, 256 samples of 255 -> same frame.
- sample_valid held high continuously for 12 cycles, vin=vout=1 -> first frame sent correctly; windows 2 and 3 complete while busy -> overrun=1 stays set, first frame bytes unchanged; next window after busy falls transmits normally.
- Reset asserted at cycle 100 of a frame -> tx=1, busy=0 next edge; following fresh 4-sample window -> complete correct frame.
